// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel serial LED strip engine.
package led_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HIGH,
      ST_LOW,
      ST_LATCH
   } state_t;

   localparam int COL_G = 0;
   localparam int COL_R = 1;
   localparam int COL_B = 2;

   function automatic int buf_size(input int led_cnt, input int ch_cnt);
      return led_cnt * ch_cnt * (COL_B - COL_G + 1);
   endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Bit-period counter shared by all strings: TBIT wrap, high-time compares and end-of-bit flag.
module led_bit_timer #(
   parameter int T0H  = 8,
   parameter int T1H  = 16,
   parameter int TBIT = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_last,
   output logic o_high_end,
   output logic o_nxt_lt_t0h,
   output logic o_nxt_lt_t1h
);

   localparam int CNT_W = $clog2(TBIT);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nxt;

   assign o_last     = (r_cnt == CNT_W'(TBIT - 1));
   assign o_high_end = (r_cnt == CNT_W'(T1H - 1));
   assign w_nxt      = o_last ? '0 : r_cnt + CNT_W'(1);

   // Compares look one count ahead so the per-channel outputs can be registered.
   assign o_nxt_lt_t0h = (w_nxt < CNT_W'(T0H));
   assign o_nxt_lt_t1h = (w_nxt < CNT_W'(T1H));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_nxt;
      end
   end

endmodule

// File: rtl/led_strip_engine.sv
// Multi-channel WS2812-style driver: byte-addressed GRB buffer, lockstep serial
// transmission of all strings, brightness shift at load, latch gap with done pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | outputs low, buffer writable, waiting for start
// ST_LOAD  | one cycle: fetch next byte per channel, apply brightness
// ST_HIGH  | bit high phase, each string drops after its T0H/T1H
// ST_LOW   | bit low phase until end of TBIT, then next bit/byte/latch
// ST_LATCH | TRESET cycles low, then done pulse and back to idle
module led_strip_engine
   import led_pkg::*;
#(
   parameter int LED_CNT = 10,
   parameter int CH_CNT  = 2,
   parameter int T0H     = 8,
   parameter int T1H     = 16,
   parameter int TBIT    = 25,
   parameter int TRESET  = 1000,
   parameter int ADDR_W  = $clog2(CH_CNT * LED_CNT * 3)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   output logic              wr_err,
   input  logic              start,
   input  logic [2:0]        bright,
   output logic              busy,
   output logic              done,
   output logic [CH_CNT-1:0] led_o
);

   localparam int BUF_SZ   = buf_size(LED_CNT, CH_CNT);
   localparam int CH_BYTES = LED_CNT * (COL_B + 1);
   localparam int BYTE_W   = $clog2(CH_BYTES);
   localparam int LAT_W    = $clog2(TRESET + 1);

   state_t              r_state;
   logic [7:0]          r_buf [BUF_SZ];
   logic [7:0]          r_shift [CH_CNT];
   logic [2:0]          r_bit_cnt;
   logic [BYTE_W-1:0]   r_byte_idx;
   logic [LAT_W-1:0]    r_lat_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_wr_err;
   logic [CH_CNT-1:0]   r_led;

   logic w_wr_ok;
   logic w_timer_en;
   logic w_last;
   logic w_high_end;
   logic w_lt_t0h;
   logic w_lt_t1h;

   assign w_wr_ok    = wr_en && !r_busy && ({1'b0, wr_addr} < (ADDR_W + 1)'(BUF_SZ));
   assign w_timer_en = (r_state == ST_HIGH) || (r_state == ST_LOW);

   assign wr_err = r_wr_err;
   assign busy   = r_busy;
   assign done   = r_done;
   assign led_o  = r_led;

   led_bit_timer #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT)
   ) u_bit_timer (
      .clk          (clk),
      .reset        (reset),
      .i_en         (w_timer_en),
      .o_last       (w_last),
      .o_high_end   (w_high_end),
      .o_nxt_lt_t0h (w_lt_t0h),
      .o_nxt_lt_t1h (w_lt_t1h)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BUF_SZ; i++) r_buf[i] <= '0;
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= wr_en && !w_wr_ok;
         if (w_wr_ok) r_buf[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_byte_idx <= '0;
         r_lat_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_led      <= '0;
         for (int c = 0; c < CH_CNT; c++) r_shift[c] <= '0;
      end else begin
         r_done <= 1'b0;
         r_led  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_LOAD;
                  r_busy     <= 1'b1;
                  r_byte_idx <= '0;
               end
            end
            ST_LOAD: begin
               for (int c = 0; c < CH_CNT; c++)
                  r_shift[c] <= r_buf[ADDR_W'(c * CH_BYTES + int'(r_byte_idx))] >> bright;
               r_bit_cnt <= 3'd7;
               r_led     <= '1;
               r_state   <= ST_HIGH;
            end
            ST_HIGH: begin
               for (int c = 0; c < CH_CNT; c++)
                  r_led[c] <= r_shift[c][7] ? w_lt_t1h : w_lt_t0h;
               if (w_high_end) r_state <= ST_LOW;
            end
            ST_LOW: begin
               if (w_last) begin
                  if (r_bit_cnt != 3'd0) begin
                     for (int c = 0; c < CH_CNT; c++)
                        r_shift[c] <= {r_shift[c][6:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt - 3'd1;
                     r_led     <= '1;
                     r_state   <= ST_HIGH;
                  end else if (r_byte_idx != BYTE_W'(CH_BYTES - 1)) begin
                     r_byte_idx <= r_byte_idx + BYTE_W'(1);
                     r_state    <= ST_LOAD;
                  end else begin
                     r_byte_idx <= '0;
                     r_lat_cnt  <= '0;
                     r_state    <= ST_LATCH;
                  end
               end
            end
            ST_LATCH: begin
               if (r_lat_cnt == LAT_W'(TRESET - 1)) begin
                  r_lat_cnt <= '0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_lat_cnt <= r_lat_cnt + LAT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_strip_engine.sv
// Scoreboard bench for led_strip_engine: expected frames and write errors are queued
// at stimulus time and checked by a monitor that decodes the serial outputs.
module tb_led_strip_engine;
   import led_pkg::*;

   localparam int LED_CNT   = 2;
   localparam int CH_CNT    = 2;
   localparam int T0H       = 2;
   localparam int T1H       = 4;
   localparam int TBIT      = 6;
   localparam int TRESET    = 10;
   localparam int NBYTE     = LED_CNT * 3;
   localparam int BUF_SZ    = CH_CNT * NBYTE;
   localparam int ADDR_W    = $clog2(BUF_SZ);
   localparam int FRAME_LEN = NBYTE * (8 * TBIT + 1) + TRESET + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_err;
   logic              start;
   logic [2:0]        bright;
   logic              busy;
   logic              done;
   logic [CH_CNT-1:0] led_o;

   led_strip_engine #(
      .LED_CNT (LED_CNT),
      .CH_CNT  (CH_CNT),
      .T0H     (T0H),
      .T1H     (T1H),
      .TBIT    (TBIT),
      .TRESET  (TRESET)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_err  (wr_err),
      .start   (start),
      .bright  (bright),
      .busy    (busy),
      .done    (done),
      .led_o   (led_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [BUF_SZ*8-1:0] data;
      logic [31:0]         start_cyc;
   } frame_t;

   int                n_tests = 0;
   int                n_fail  = 0;
   logic [7:0]        m_buf [BUF_SZ];
   int                m_start = -1000;
   int                m_done  = -1000;
   frame_t            exp_q[$];
   int                err_q[$];
   logic [CH_CNT-1:0] cap[$];
   logic [CH_CNT-1:0] ew[$];
   logic [CH_CNT-1:0] wv;
   frame_t            mf;
   logic [NBYTE*8-1:0] exp_bits;
   int                bad;
   logic              exp_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: buffer image plus busy window derived from the frame length.
   task automatic drive(input logic we, input int addr, input logic [7:0] data, input logic st);
      logic   m_busy;
      frame_t f;
      @(posedge clk); #1;
      wr_en   = we;
      wr_addr = ADDR_W'(addr);
      wr_data = data;
      start   = st;
      m_busy  = (cyc > m_start) && (cyc < m_done);
      if (we) begin
         if (!m_busy && addr < BUF_SZ) m_buf[addr] = data;
         else err_q.push_back(cyc + 1);
      end
      if (st && !m_busy) begin
         for (int i = 0; i < BUF_SZ; i++) f.data[i*8 +: 8] = m_buf[i] >> bright;
         f.start_cyc = 32'(cyc);
         exp_q.push_back(f);
         m_start = cyc;
         m_done  = cyc + FRAME_LEN;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 8'h00, 1'b0);
   endtask

   task automatic wait_frame();
      while (cyc <= m_done) idle(1);
      check("frame_pending", 64'(exp_q.size()), 0);
      check("busy_after_frame", busy, 0);
   endtask

   function automatic logic [NBYTE*8-1:0] decode(input int c);
      logic [NBYTE*8-1:0] v = '0;
      int run = 0;
      for (int i = 0; i < cap.size(); i++) begin
         if (cap[i][c]) run++;
         else if (run > 0) begin
            v   = {v[NBYTE*8-2:0], (run * 2 > T0H + T1H)};
            run = 0;
         end
      end
      return v;
   endfunction

   // Monitor: write-error pulses and complete frames.
   always @(negedge clk) begin
      exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      if (!reset && (wr_err || exp_err)) check("wr_err_pulse", wr_err, exp_err);

      if (reset) cap.delete();
      else if (busy) cap.push_back(led_o);

      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            mf = exp_q.pop_front();
            check("done_cycle", cyc, int'(mf.start_cyc) + FRAME_LEN);
            check("busy_at_done", busy, 0);
            ew.delete();
            for (int k = 0; k < NBYTE; k++) begin
               ew.push_back('0);
               for (int b = 7; b >= 0; b--)
                  for (int t = 0; t < TBIT; t++) begin
                     for (int c = 0; c < CH_CNT; c++)
                        wv[c] = (t < (mf.data[(c*NBYTE+k)*8+b] ? T1H : T0H));
                     ew.push_back(wv);
                  end
            end
            repeat (TRESET) ew.push_back('0);
            check("frame_samples", 64'(cap.size()), 64'(ew.size()));
            bad = -1;
            for (int i = 0; i < ew.size() && i < cap.size(); i++)
               if (bad < 0 && cap[i] !== ew[i]) bad = i;
            n_tests++;
            if (bad >= 0) begin
               n_fail++;
               $display("FAIL waveform: sample %0d got %b, expected %b", bad, cap[bad], ew[bad]);
            end
            for (int c = 0; c < CH_CNT; c++) begin
               for (int k = 0; k < NBYTE; k++)
                  exp_bits[(NBYTE-1-k)*8 +: 8] = mf.data[(c*NBYTE+k)*8 +: 8];
               check($sformatf("bytes_ch%0d", c), decode(c), exp_bits);
            end
            cap.delete();
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < BUF_SZ; i++) m_buf[i] = 8'h00;
      reset = 1'b1; wr_en = 1'b0; start = 1'b0;
      wr_addr = '0; wr_data = '0; bright = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_led_o", led_o, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_err", wr_err, 0);
      reset = 1'b0;

      // ch0 LED0 G = 0x80: one long bit on string 0, everything else short.
      drive(1'b1, COL_G, 8'h80, 1'b0);
      drive(1'b0, 0, 8'h00, 1'b1);
      wait_frame();

      // Brightness shift: 0xFF goes out as 0x7F.
      bright = 3'd1;
      drive(1'b1, 3 + COL_G, 8'hFF, 1'b0);
      drive(1'b0, 0, 8'h00, 1'b1);
      wait_frame();
      bright = 3'd0;

      // Out-of-range write, then a write while busy.
      drive(1'b1, 12, 8'h55, 1'b0);
      idle(2);
      drive(1'b0, 0, 8'h00, 1'b1);
      idle(20);
      drive(1'b1, 0, 8'hAA, 1'b0);
      wait_frame();
      drive(1'b0, 0, 8'h00, 1'b1);
      // Start mid-frame must be ignored.
      idle(100);
      drive(1'b0, 0, 8'h00, 1'b1);
      wait_frame();
      idle(FRAME_LEN + 5);
      check("no_second_frame_busy", busy, 0);

      // Reset during a HIGH phase, then an all-zero frame.
      drive(1'b0, 0, 8'h00, 1'b1);
      idle(2);
      @(posedge clk); #1;
      check("pre_reset_led_high", led_o, {CH_CNT{1'b1}});
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_reset_led_o", led_o, 0);
      check("mid_reset_busy", busy, 0);
      reset = 1'b0;
      void'(exp_q.pop_back());
      m_start = -1000; m_done = -1000;
      for (int i = 0; i < BUF_SZ; i++) m_buf[i] = 8'h00;
      drive(1'b0, 0, 8'h00, 1'b1);
      wait_frame();

      // Write and start in the same cycle: ch1 LED1 B = 0x01.
      drive(1'b1, (1 * LED_CNT + 1) * 3 + COL_B, 8'h01, 1'b1);
      wait_frame();

      // Randomised frames with random writes, brightness and ignored mid-frame traffic.
      for (int f = 0; f < 6; f++) begin
         bright = 3'($urandom_range(0, 3));
         repeat ($urandom_range(3, 8))
            drive(1'b1, $urandom_range(0, 15), 8'($urandom), 1'b0);
         drive(1'b0, 0, 8'h00, 1'b1);
         for (int j = 0; j < 3; j++) begin
            idle($urandom_range(1, 80));
            drive(1'b1, $urandom_range(0, 15), 8'($urandom), 1'($urandom_range(0, 1)));
         end
         wait_frame();
      end

      idle(5);
      check("err_q_drained", 64'(err_q.size()), 0);
      check("exp_q_drained", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
